shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits (at least 2).
REQ-002 Parameter AMT_W, default 3: shift-amount width, equal to clog2(WIDTH).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start_valid, input, 1 bit: request present on op_in/amt.
REQ-006 Port start_ready, output, 1 bit: block can accept a request.
REQ-007 Port op_in, input, WIDTH bits: operand to shift.
REQ-008 Port amt, input, AMT_W bits: number of right-shift positions, 0..WIDTH-1.
REQ-009 Port res_valid, output, 1 bit: result, carry_out and the held value are valid.
REQ-010 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 Port result, output, WIDTH bits: shifted value.
REQ-012 Port carry_out, output, 1 bit: last bit shifted out of bit 0.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have three states (IDLE, SHIFT, DONE) and SHALL never enter any other state.
REQ-015 start_ready SHALL be high only in IDLE; a request is accepted on the cycle where start_valid and start_ready are both high.
REQ-016 On accept, the block SHALL load op_in into the working register and amt into the remaining-shift counter, and clear carry_out.
REQ-017 If the accepted amt is nonzero, the FSM SHALL go IDLE->SHIFT; if amt is 0, it SHALL go IDLE->DONE.
REQ-018 Each cycle in SHIFT, the block SHALL perform exactly one 1-bit right shift, capture bit 0 into carry_out, and decrement the counter.
REQ-019 When the counter decrements to 0, the FSM SHALL go SHIFT->DONE on the same edge.
REQ-020 Latency from the accept edge to res_valid high SHALL be amt+1 cycles (1 cycle for amt=0).
REQ-021 res_valid SHALL be high only in DONE; result and carry_out SHALL stay stable while res_valid is high and res_ready is low.
REQ-022 On res_valid and res_ready both high, the FSM SHALL go DONE->IDLE, so start_ready rises on the next cycle (no same-cycle re-accept).
REQ-023 start_valid SHALL be ignored while busy; op_in and amt SHALL be sampled only on the accept edge.
REQ-024 In IDLE, result and carry_out SHALL hold the last completed values.
REQ-025 The vacated MSB SHALL be filled with 0 (see REQ-029 for the alternative).

Reset
REQ-026 rst_n low SHALL force IDLE immediately, independent of clk, and drive result=0, carry_out=0, res_valid=0, busy=0 and the counter to 0.
REQ-027 start_ready SHALL be high while rst_n is low and SHALL stay high after release.
REQ-028 Reset asserted during SHIFT or DONE SHALL discard the operation with no res_valid pulse after release.

Configuration
REQ-029 With macro SHIFT_RIGHT_SEQ_ARITH_EN defined, each shift SHALL fill the MSB with the current MSB (arithmetic shift); without it, the fill SHALL be 0 (logical shift). Timing and handshake are identical in both builds.

Verification
REQ-030 op_in=8'b00001111, amt=1, res_ready=1 -> result=8'b00000111, carry_out=1, res_valid high 2 cycles after accept, for 1 cycle.
REQ-031 op_in=8'h81, amt=7 -> result=8'h01, carry_out=0 without the macro; result=8'hFF, carry_out=0 with SHIFT_RIGHT_SEQ_ARITH_EN; res_valid 8 cycles after accept.
REQ-032 op_in=8'hA5, amt=0 -> result=8'hA5, carry_out=0, res_valid 1 cycle after accept.
REQ-033 Backpressure: op_in=8'hF0, amt=4, res_ready held low 3 cycles after res_valid -> result=8'h0F held stable, start_ready low, second start_valid ignored; res_ready high -> start_ready high on the next cycle.
REQ-034 rst_n pulsed low mid-SHIFT (op_in=8'hFF, amt=5, after 2 shifts) -> immediate IDLE, result=0, no res_valid afterwards; next request (8'h80, amt=3) -> result=8'h10 (logical build).

Source files
------------

// File: rtl/shift_right_seq_if.sv
// Handshake bundle for shift_right_seq: request channel (start_*, op_in, amt)
// and result channel (res_*, result, carry_out), plus the busy status flag.
interface shift_right_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_in;
  logic [AMT_W-1:0] amt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;

  modport master (
    output start_valid,
    output op_in,
    output amt,
    output res_ready,
    input  start_ready,
    input  res_valid,
    input  result,
    input  carry_out,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  op_in,
    input  amt,
    input  res_ready,
    output start_ready,
    output res_valid,
    output result,
    output carry_out,
    output busy
  );

endinterface

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per cycle, IDLE -> SHIFT -> DONE FSM.
// Ports: clk, rst_n (async active-low), bus (shift_right_seq_if.slave):
//   start_valid/start_ready/op_in/amt in, res_valid/res_ready/result/
//   carry_out out, busy status.
// Build option: define SHIFT_RIGHT_SEQ_ARITH_EN for arithmetic (sign-fill)
// shifts; default build fills the vacated MSB with 0.
module shift_right_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_right_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] cnt_d;
  logic             carry_q;
  logic             carry_d;
  logic             fill;
  logic             accept;
  logic             release_res;

`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
  assign fill = work_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = work_q;
  assign bus.carry_out   = carry_q;

  assign accept      = bus.start_valid & bus.start_ready;
  assign release_res = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = bus.op_in;
          cnt_d   = bus.amt;
          carry_d = 1'b0;
          if (bus.amt != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        work_d  = {fill, work_q[WIDTH-1:1]};
        carry_d = work_q[0];
        cnt_d   = cnt_q - AMT_W'(1);
        // Last shift lands on the same edge as the move to DONE.
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (release_res) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: handshake, latency, backpressure,
// async reset mid-operation; expected values computed by hand.
module tb_shift_right_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;
  logic seen_valid;
  logic [7:0] hold_res;

  shift_right_seq_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_right_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; returns edges from accept to res_valid.
  task automatic run(input logic [7:0] op, input logic [2:0] a,
                     output int l);
    bus.start_valid = 1'b1;
    bus.op_in       = op;
    bus.amt         = a;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.op_in       = 8'h00;
    bus.amt         = 3'd0;
    l = 1;
    while (!bus.res_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_in       = 8'h00;
    bus.amt         = 3'd0;
    bus.res_ready   = 1'b0;
    #12;
    chk("rst_result", 32'(bus.result), 32'h00);
    chk("rst_carry", 32'(bus.carry_out), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_start_ready", 32'(bus.start_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.start_ready), 32'h1);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    bus.res_ready = 1'b1;
    run(8'h0F, 3'd1, lat);
    chk("v0f_lat", 32'(lat), 32'd2);
    chk("v0f_result", 32'(bus.result), 32'h07);
    chk("v0f_carry", 32'(bus.carry_out), 32'h1);
    @(negedge clk);
    chk("v0f_pulse", 32'(bus.res_valid), 32'h0);
    chk("v0f_ready", 32'(bus.start_ready), 32'h1);
    chk("v0f_hold", 32'(bus.result), 32'h07);

    run(8'hA5, 3'd0, lat);
    chk("va5_lat", 32'(lat), 32'd1);
    chk("va5_result", 32'(bus.result), 32'hA5);
    chk("va5_carry", 32'(bus.carry_out), 32'h0);
    @(negedge clk);

    run(8'h81, 3'd7, lat);
    chk("v81_lat", 32'(lat), 32'd8);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    chk("v81_result", 32'(bus.result), 32'hFF);
`else
    chk("v81_result", 32'(bus.result), 32'h01);
`endif
    chk("v81_carry", 32'(bus.carry_out), 32'h0);
    @(negedge clk);

    run(8'hB6, 3'd3, lat);
    chk("vb6_lat", 32'(lat), 32'd4);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    chk("vb6_result", 32'(bus.result), 32'hF6);
`else
    chk("vb6_result", 32'(bus.result), 32'h16);
`endif
    chk("vb6_carry", 32'(bus.carry_out), 32'h1);
    @(negedge clk);

    bus.res_ready = 1'b0;
    run(8'hF0, 3'd4, lat);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    hold_res = 8'hFF;
`else
    hold_res = 8'h0F;
`endif
    chk("vf0_lat", 32'(lat), 32'd5);
    chk("vf0_carry", 32'(bus.carry_out), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", 32'(bus.result), 32'(hold_res));
      chk("bp_valid", 32'(bus.res_valid), 32'h1);
      chk("bp_ready_low", 32'(bus.start_ready), 32'h0);
      bus.start_valid = 1'b1;
      bus.op_in       = 8'h33;
      bus.amt         = 3'd0;
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    chk("bp_ignored", 32'(bus.result), 32'(hold_res));
    chk("bp_carry", 32'(bus.carry_out), 32'h0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.start_ready), 32'h1);
    chk("bp_release_valid", 32'(bus.res_valid), 32'h0);
    chk("idle_hold", 32'(bus.result), 32'(hold_res));

    bus.start_valid = 1'b1;
    bus.op_in       = 8'hFF;
    bus.amt         = 3'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_ready", 32'(bus.start_ready), 32'h1);
    chk("arst_result", 32'(bus.result), 32'h00);
    chk("arst_carry", 32'(bus.carry_out), 32'h0);
    chk("arst_valid", 32'(bus.res_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen_valid = 1'b1;
    end
    chk("arst_no_valid", 32'(seen_valid), 32'h0);
    chk("arst_ready_after", 32'(bus.start_ready), 32'h1);

    run(8'h80, 3'd3, lat);
    chk("v80_lat", 32'(lat), 32'd4);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    chk("v80_result", 32'(bus.result), 32'hF0);
`else
    chk("v80_result", 32'(bus.result), 32'h10);
`endif
    chk("v80_carry", 32'(bus.carry_out), 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
